// File: rtl/life_pkg.sv
// Shared constants for the Game of Life engine: grid defaults, neighbour-count
// width, default seed pattern and the cell-to-seed-bit mapping.
// Optional macro LIFE_TORUS_EN (used by life_matrix) selects wrap-around edges.
package life_pkg;

   localparam int ROWS_DEF = 8;
   localparam int COLS_DEF = 8;
   localparam int NCNT_W   = 4;

   // Glider at (0,1),(1,2),(2,0),(2,1),(2,2)
   localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_0007_0402;

   // Bit position in SEED holding the reset state of cell [r][c]
   function automatic int seed_idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

endpackage

// File: rtl/life_cell.sv
// One Game of Life cell: counts live neighbours and applies survive/birth rule.
// Latency: new state registered one clock after the neighbour states it used.
// No backpressure; the cell updates on every rising edge.
module life_cell
   import life_pkg::*;
(
   input  logic       clk,
   input  logic       _rst,
   input  logic       seed_bit,
   input  logic [7:0] nbr,
   output logic       state
);

   logic [NCNT_W-1:0] n_cnt;
   logic              state_d;
   logic              state_q;

   // Popcount of the eight neighbours and the next-generation rule
   always_comb begin
      n_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         n_cnt = n_cnt + {{(NCNT_W-1){1'b0}}, nbr[i]};
      end
      state_d = (n_cnt == NCNT_W'(3)) || (state_q && (n_cnt == NCNT_W'(2)));
   end

   // Cell register; reset reloads the seed bit regardless of current state
   always_ff @(posedge clk) begin
      if (!_rst) begin
         state_q <= seed_bit;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/life_matrix.sv
// ROWS x COLS Game of Life array; advances one generation per clock out of reset.
// Latency: one cycle per generation; grid comes straight from the cell registers.
// No backpressure. Macro LIFE_TORUS_EN wraps edges; otherwise off-grid cells are dead.
module life_matrix
   import life_pkg::*;
#(
   parameter int                    ROWS = ROWS_DEF,
   parameter int                    COLS = COLS_DEF,
   parameter logic [ROWS*COLS-1:0]  SEED = (ROWS*COLS)'(DEFAULT_SEED)
)(
   input  logic                         clk,
   input  logic                         _rst,
   output logic [0:ROWS-1][0:COLS-1]    grid
);

   logic [0:ROWS-1][0:COLS-1] cell_st;

   assign grid = cell_st;

   for (genvar R = 0; R < ROWS; R++) begin : g_row
      for (genvar C = 0; C < COLS; C++) begin : g_col
         logic [7:0] nbr;

         // Offsets k = 0..8 cover the 3x3 window; k == 4 is the cell itself
         for (genvar K = 0; K < 9; K++) begin : g_nbr
            localparam int DR   = K / 3 - 1;
            localparam int DC   = K % 3 - 1;
            localparam int SLOT = (K < 4) ? K : K - 1;
            if (K != 4) begin : g_used
`ifdef LIFE_TORUS_EN
               localparam int NR = (R + DR + ROWS) % ROWS;
               localparam int NC = (C + DC + COLS) % COLS;
               assign nbr[SLOT] = cell_st[NR][NC];
`else
               if ((R + DR < 0) || (R + DR >= ROWS) ||
                   (C + DC < 0) || (C + DC >= COLS)) begin : g_edge
                  assign nbr[SLOT] = 1'b0;
               end else begin : g_in
                  assign nbr[SLOT] = cell_st[R+DR][C+DC];
               end
`endif
            end
         end

         life_cell u_cell (
            .clk      (clk),
            ._rst     (_rst),
            .seed_bit (SEED[seed_idx(R, C, COLS)]),
            .nbr      (nbr),
            .state    (cell_st[R][C])
         );
      end
   end

endmodule

// File: tb/tb_life_matrix.sv
// Self-checking bench for life_matrix: five instances with different seeds
// share clock and reset and are compared with a plain array-based Life model.
// Follows LIFE_TORUS_EN the same way the design does.
module tb_life_matrix;

   typedef logic [0:7][0:7] grid_t;
   localparam int NI = 5;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   grid_t dut_g [NI];
   grid_t mdl   [NI];
   grid_t sd    [NI];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   life_matrix                               u_glider (.clk(clk), ._rst(rst_n), .grid(dut_g[0]));
   life_matrix #(.SEED(64'h0000_0000_0000_0007)) u_blink  (.clk(clk), ._rst(rst_n), .grid(dut_g[1]));
   life_matrix #(.SEED(64'h0000_0000_0000_0303)) u_block  (.clk(clk), ._rst(rst_n), .grid(dut_g[2]));
   life_matrix #(.SEED(64'h0000_0000_0000_0000)) u_zero   (.clk(clk), ._rst(rst_n), .grid(dut_g[3]));
   life_matrix #(.SEED(64'hA5C3_1F0E_9B27_6D48)) u_rand   (.clk(clk), ._rst(rst_n), .grid(dut_g[4]));

   function automatic grid_t from_seed(input logic [63:0] s);
      grid_t g;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            g[r][c] = s[r*8+c];
      return g;
   endfunction

   // Reference: count live cells in the 3x3 window around each cell
   function automatic grid_t life_next(input grid_t g);
      grid_t nx;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr = r + dr;
                  int cc = c + dc;
                  if (dr == 0 && dc == 0) continue;
`ifdef LIFE_TORUS_EN
                  rr = (rr + 8) % 8;
                  cc = (cc + 8) % 8;
`else
                  if (rr < 0 || rr > 7 || cc < 0 || cc > 7) continue;
`endif
                  if (g[rr][cc]) n++;
               end
            end
            nx[r][c] = g[r][c] ? (n == 2 || n == 3) : (n == 3);
         end
      end
      return nx;
   endfunction

   // One clock edge: model follows the reset value being driven, sample at negedge
   task automatic step();
      @(posedge clk);
      for (int i = 0; i < NI; i++)
         mdl[i] = rst_n ? life_next(mdl[i]) : sd[i];
      @(negedge clk);
   endtask

   task automatic test_reset();
      grid_t exp_g;
      rst_n = 1'b0;
      step();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (dut_g[i] !== mdl[i]) begin
            errors++;
            $display("FAIL reset_inst%0d got=%h exp=%h", i, dut_g[i], mdl[i]);
         end
      end
      exp_g = '0;
      exp_g[0][1] = 1'b1; exp_g[1][2] = 1'b1;
      exp_g[2][0] = 1'b1; exp_g[2][1] = 1'b1; exp_g[2][2] = 1'b1;
      checks++;
      if (dut_g[0] !== exp_g) begin
         errors++;
         $display("FAIL reset_glider got=%h exp=%h", dut_g[0], exp_g);
      end
   endtask

   task automatic test_glider();
      grid_t exp_g;
      rst_n = 1'b1;
      step();
      exp_g = '0;
      exp_g[1][0] = 1'b1; exp_g[1][2] = 1'b1; exp_g[2][1] = 1'b1;
      exp_g[2][2] = 1'b1; exp_g[3][1] = 1'b1;
      checks++;
      if (dut_g[0] !== exp_g) begin
         errors++;
         $display("FAIL glider_gen1 got=%h exp=%h", dut_g[0], exp_g);
      end
      // Blinker rotates on the first generation
      exp_g = '0;
      exp_g[0][1] = 1'b1; exp_g[1][1] = 1'b1;
`ifdef LIFE_TORUS_EN
      exp_g[7][1] = 1'b1;
`endif
      checks++;
      if (dut_g[1] !== exp_g) begin
         errors++;
         $display("FAIL blinker_gen1 got=%h exp=%h", dut_g[1], exp_g);
      end
      for (int k = 0; k < 3; k++) step();
      exp_g = '0;
      exp_g[1][2] = 1'b1; exp_g[2][3] = 1'b1; exp_g[3][1] = 1'b1;
      exp_g[3][2] = 1'b1; exp_g[3][3] = 1'b1;
      checks++;
      if (dut_g[0] !== exp_g) begin
         errors++;
         $display("FAIL glider_gen4 got=%h exp=%h", dut_g[0], exp_g);
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (dut_g[i] !== mdl[i]) begin
            errors++;
            $display("FAIL gen4_inst%0d got=%h exp=%h", i, dut_g[i], mdl[i]);
         end
      end
   endtask

   // Block is a still life and the empty grid stays empty; glider runs 32 gens
   task automatic test_long_run();
      grid_t blk;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      blk = '0;
      blk[0][0] = 1'b1; blk[0][1] = 1'b1; blk[1][0] = 1'b1; blk[1][1] = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         step();
         if (k <= 10) begin
            checks++;
            if (dut_g[2] !== blk) begin
               errors++;
               $display("FAIL block_gen%0d got=%h exp=%h", k, dut_g[2], blk);
            end
            checks++;
            if (dut_g[3] !== '0) begin
               errors++;
               $display("FAIL zero_gen%0d got=%h exp=0", k, dut_g[3]);
            end
         end
      end
`ifdef LIFE_TORUS_EN
      checks++;
      if (dut_g[0] !== from_seed(64'h0000_0000_0007_0402)) begin
         errors++;
         $display("FAIL torus_wrap32 got=%h exp=%h", dut_g[0], from_seed(64'h0000_0000_0007_0402));
      end
`endif
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (dut_g[i] !== mdl[i]) begin
            errors++;
            $display("FAIL gen32_inst%0d got=%h exp=%h", i, dut_g[i], mdl[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      grid_t exp_g;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) step();
      rst_n = 1'b0;
      step();
      checks++;
      if (dut_g[0] !== from_seed(64'h0000_0000_0007_0402)) begin
         errors++;
         $display("FAIL midreset_seed got=%h exp=%h", dut_g[0], from_seed(64'h0000_0000_0007_0402));
      end
      rst_n = 1'b1;
      step();
      exp_g = '0;
      exp_g[1][0] = 1'b1; exp_g[1][2] = 1'b1; exp_g[2][1] = 1'b1;
      exp_g[2][2] = 1'b1; exp_g[3][1] = 1'b1;
      checks++;
      if (dut_g[0] !== exp_g) begin
         errors++;
         $display("FAIL midreset_gen1 got=%h exp=%h", dut_g[0], exp_g);
      end
   endtask

   // Random run lengths with sporadic reset pulses, every instance every cycle
   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         rst_n = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (dut_g[i] !== mdl[i]) begin
               errors++;
               $display("FAIL random_c%0d_inst%0d got=%h exp=%h", k, i, dut_g[i], mdl[i]);
            end
         end
      end
   endtask

   initial begin
      sd[0] = from_seed(64'h0000_0000_0007_0402);
      sd[1] = from_seed(64'h0000_0000_0000_0007);
      sd[2] = from_seed(64'h0000_0000_0000_0303);
      sd[3] = from_seed(64'h0000_0000_0000_0000);
      sd[4] = from_seed(64'hA5C3_1F0E_9B27_6D48);
      for (int i = 0; i < NI; i++) mdl[i] = sd[i];
      @(negedge clk);
      test_reset();
      test_glider();
      test_long_run();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
